// File: rtl/bounce_generator_if.sv
// bounce_generator_if: trigger and status bundle between a requester (master) and bounce_generator (slave).
//   i_trigger : requester -> generator, request one level change
//   o_bouncy  : generator -> requester, chattering switch level
//   o_clean   : generator -> requester, ideal level, updated at completion
//   o_busy    : generator -> requester, burst or settle in progress
//   o_done    : generator -> requester, one-cycle completion pulse
interface bounce_generator_if;
    logic i_trigger;
    logic o_bouncy;
    logic o_clean;
    logic o_busy;
    logic o_done;
    modport master (output i_trigger, input o_bouncy, o_clean, o_busy, o_done);
    modport slave (input i_trigger, output o_bouncy, o_clean, o_busy, o_done);
endinterface

// File: rtl/bounce_generator.sv
// bounce_generator: turns a clean trigger into a bouncy switch level change (random glitch burst, then settle).
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : bounce_generator_if.slave (i_trigger in; o_bouncy, o_clean, o_busy, o_done out)
module bounce_generator #(
    parameter int unsigned BOUNCE_COUNT  = 8,
    parameter int unsigned GAP_WIDTH     = 8,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    bounce_generator_if.slave bus
);
    localparam int unsigned EDGES = 2 * BOUNCE_COUNT + 1;
    localparam int unsigned EW = $clog2(2 * BOUNCE_COUNT + 2);
    localparam int unsigned GW = GAP_WIDTH + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic          bouncy_q, bouncy_d;
    logic          clean_q, clean_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [GW-1:0] gap;
    logic [EW-1:0] edge_nxt;

    // Extra top bit keeps 2^GAP_WIDTH representable after the +1.
    assign gap = {1'b0, lfsr_q[GAP_WIDTH-1:0]} + GW'(1);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        edge_cnt_d   = edge_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        settle_cnt_d = settle_cnt_q;
        bouncy_d     = bouncy_q;
        clean_d      = clean_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        edge_nxt     = edge_cnt_q + EW'(1);
        case (state_q)
            IDLE: begin
                if (bus.i_trigger) begin
                    bouncy_d   = ~bouncy_q;
                    busy_d     = 1'b1;
                    edge_cnt_d = EW'(1);
                    gap_cnt_d  = gap;
                    if (EDGES == 1) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SW'(SETTLE_CYCLES);
                    end else begin
                        state_d = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                // Edge fires when the counter is at 1, so edges sit exactly gap cycles apart.
                if (gap_cnt_q == GW'(1)) begin
                    bouncy_d   = ~bouncy_q;
                    edge_cnt_d = edge_nxt;
                    gap_cnt_d  = gap;
                    if (edge_nxt == EW'(EDGES)) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SW'(SETTLE_CYCLES);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(1)) begin
                    clean_d      = bouncy_q;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                    edge_cnt_d   = '0;
                    gap_cnt_d    = '0;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            edge_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            settle_cnt_q <= '0;
            bouncy_q     <= 1'b0;
            clean_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            edge_cnt_q   <= edge_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            bouncy_q     <= bouncy_d;
            clean_q      <= clean_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_bouncy = bouncy_q;
    assign bus.o_clean  = clean_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: scoreboard bench for bounce_generator (burst config a: 3 pairs, 4-bit gaps, settle 20; clean config z: 0 pairs, settle 4).
module tb_bounce_generator;
    typedef struct {
        int t;
        bit done;
        bit lvl;
        bit cln;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bounce_generator_if a_if ();
    bounce_generator_if z_if ();

    bounce_generator #(.BOUNCE_COUNT(3), .GAP_WIDTH(4), .SETTLE_CYCLES(20)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(a_if.slave)
    );
    bounce_generator #(.BOUNCE_COUNT(0), .GAP_WIDTH(4), .SETTLE_CYCLES(4)) dut_z (
        .i_clk(clk), .i_rst_n(rst_n), .bus(z_if.slave)
    );

    evt_t        q[2][$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] lfsr_m;
    bit          lvl[2];
    bit          prev_b[2];

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: value held here during a cycle is the one the DUT samples at the next edge.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_m <= 16'hACE1;
        else lfsr_m <= step(lfsr_m);

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at the negedge on which a trigger is raised; queues every edge and the done pulse.
    function automatic void predict(input int id, input int bc, input int gw, input int s);
        logic [15:0] l = lfsr_m;
        int t = cyc + 1;
        int g;
        bit pre = lvl[id];
        evt_t e;
        for (int k = 0; k < 2 * bc + 1; k++) begin
            lvl[id] = !lvl[id];
            e.t = t; e.done = 1'b0; e.lvl = lvl[id]; e.cln = pre;
            q[id].push_back(e);
            g = (int'(l) % (1 << gw)) + 1;
            if (k < 2 * bc) begin
                for (int j = 0; j < g; j++) l = step(l);
                t += g;
            end
        end
        e.t = t + s; e.done = 1'b1; e.lvl = lvl[id]; e.cln = lvl[id];
        q[id].push_back(e);
    endfunction

    task automatic observe(input int id, input logic b, input logic d, input logic bz, input logic c);
        evt_t e;
        if (b !== prev_b[id] || d === 1'b1) begin
            if (q[id].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_evt[%0d]: bouncy=%0b done=%0b at cycle %0d, required no event", id, b, d, cyc);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("evt_time[%0d]", id), cyc, e.t);
                chk($sformatf("evt_kind[%0d]", id), int'(d), int'(e.done));
                chk($sformatf("bouncy[%0d]", id), int'(b), int'(e.lvl));
                chk($sformatf("busy[%0d]", id), int'(bz), int'(!e.done));
                chk($sformatf("clean[%0d]", id), int'(c), int'(e.cln));
            end
        end
        prev_b[id] = b;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, a_if.o_bouncy, a_if.o_done, a_if.o_busy, a_if.o_clean);
            observe(1, z_if.o_bouncy, z_if.o_done, z_if.o_busy, z_if.o_clean);
        end else begin
            prev_b[0] = 1'b0;
            prev_b[1] = 1'b0;
        end
    end

    task automatic check_zero(input string nm);
        chk(nm, int'({a_if.o_bouncy, a_if.o_clean, a_if.o_busy, a_if.o_done,
                      z_if.o_bouncy, z_if.o_clean, z_if.o_busy, z_if.o_done}), 0);
    endtask

    task automatic pulse(input int id);
        if (id == 0) begin
            a_if.i_trigger = 1'b1;
            predict(0, 3, 4, 20);
        end else begin
            z_if.i_trigger = 1'b1;
            predict(1, 0, 4, 4);
        end
        @(negedge clk);
        a_if.i_trigger = 1'b0;
        z_if.i_trigger = 1'b0;
    endtask

    task automatic drain(input int id);
        int n = 0;
        while (q[id].size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tests++;
        if (q[id].size() != 0) begin
            fails++;
            $display("FAIL drain[%0d]: %0d events pending, required 0", id, q[id].size());
            q[id].delete();
        end
    endtask

    initial begin
        int n;
        a_if.i_trigger = 1'b0;
        z_if.i_trigger = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("reset_idle");

        pulse(1);
        drain(1);
        pulse(1);
        drain(1);
        chk("z_final_level", int'(z_if.o_bouncy), 0);

        pulse(0);
        drain(0);
        chk("a_final_level1", int'(a_if.o_bouncy), 1);
        pulse(0);
        drain(0);
        chk("a_final_level0", int'(a_if.o_bouncy), 0);

        pulse(0);
        for (int k = 0; k < 5; k++) begin
            repeat (3) @(negedge clk);
            if (a_if.o_busy) a_if.i_trigger = 1'b1;
            @(negedge clk);
            a_if.i_trigger = 1'b0;
        end
        drain(0);
        chk("a_busy_reject_level", int'(a_if.o_bouncy), 1);

        z_if.i_trigger = 1'b1;
        predict(1, 0, 4, 4);
        for (int k = 0; k < 2; k++) begin
            repeat (5) @(negedge clk);
            predict(1, 0, 4, 4);
        end
        @(negedge clk);
        z_if.i_trigger = 1'b0;
        drain(1);
        chk("z_held_level", int'(z_if.o_bouncy), 1);

        pulse(0);
        n = 0;
        while (q[0].size() > 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_edge4", int'(q[0].size() <= 4), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_burst");
        q[0].delete();
        q[1].delete();
        lvl[0] = 1'b0;
        lvl[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(0);
        drain(0);
        chk("a_after_reset_level", int'(a_if.o_bouncy), 1);
        chk("a_invariant", int'(a_if.o_clean), int'(a_if.o_bouncy));
        chk("z_invariant", int'(z_if.o_clean), int'(z_if.o_bouncy));
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Synthesises a mechanically bouncy switch signal from a single clean trigger pulse.
- Each trigger requests one level change on o_bouncy. The output first chatters with a pseudo-random burst of glitch transitions, then settles at the new level.
- Drives debounce_filter's i_bouncy input for on-board and simulation loopback testing, which removes the need for a physical switch.
- o_clean gives the ideal reference level to compare against the debouncer output.

Parameters:
- BOUNCE_COUNT, 8: glitch pulse pairs per transition; total edges on o_bouncy per trigger = 2*BOUNCE_COUNT+1.
- GAP_WIDTH, 8: width of the random gap field; the gap between edges is 1..2^GAP_WIDTH cycles.
- SETTLE_CYCLES, 1000: stable-hold cycles after the final edge before completion; must be >= 1.
- LFSR_SEED, 16'hACE1: LFSR reset value; a seed of 0 is replaced with 16'h0001.

Ports:
- i_clk, in, 1: system clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_trigger, in, 1: request one level transition; sampled on each rising edge; acted on only in IDLE.
- o_bouncy, out, 1: bouncy output, fed to debounce_filter.i_bouncy.
- o_clean, out, 1: ideal level, updated only at completion.
- o_busy, out, 1: high while a burst or settle is in progress.
- o_done, out, 1: one-cycle pulse when settle completes.

Behaviour:
- Reset (async assert, sync release):
  - o_bouncy=0, o_clean=0, o_busy=0, o_done=0.
  - State=IDLE, lfsr=LFSR_SEED (or 1 if the seed is 0), all counters 0.
  - Reset mid-burst abandons the burst immediately; no o_done is produced.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in every state.
- gap value = lfsr[GAP_WIDTH-1:0] + 1, sampled at the moment each edge is emitted.
- State machine:
  - IDLE → BOUNCE: i_trigger=1 at edge T.
    - At T+1: o_bouncy toggles, o_busy=1, edge_cnt=1, gap_cnt loaded with gap.
  - BOUNCE: gap_cnt decrements each cycle. When it reaches 1, the next edge toggles o_bouncy, increments edge_cnt and reloads gap_cnt.
    - Consecutive edges are therefore exactly gap cycles apart.
  - BOUNCE → SETTLE: on the cycle edge_cnt reaches 2*BOUNCE_COUNT+1; settle_cnt is loaded with SETTLE_CYCLES.
    - BOUNCE_COUNT=0: the single edge at T+1 goes directly to SETTLE.
  - SETTLE: o_bouncy is held constant. settle_cnt decrements; when it reaches 1, the next edge:
    - sets o_clean=o_bouncy;
    - pulses o_done=1 for one cycle;
    - sets o_busy=0;
    - returns to IDLE.
  - IDLE is re-entered in the o_done cycle. A trigger sampled in that same cycle is accepted.
- i_trigger while o_busy=1 is ignored: no queuing, no effect on timing.
- A trigger held high continuously retriggers on every IDLE entry.
- Final o_bouncy level after every burst = inverse of the level before the trigger. An odd edge count guarantees this.
- Invariant: o_clean == o_bouncy whenever o_busy=0.
- Counter widths:
  - edge_cnt: $clog2(2*BOUNCE_COUNT+2).
  - gap_cnt: GAP_WIDTH+1 bits.
  - settle_cnt: $clog2(SETTLE_CYCLES+1).
  - No overflow is possible.
- Worst-case burst duration = (2*BOUNCE_COUNT)*2^GAP_WIDTH + SETTLE_CYCLES + 1 cycles.

Test Plan:
1. Reset values: assert i_rst_n=0 asynchronously mid-cycle → all outputs 0 immediately; release → outputs stay 0 and o_busy=0 with no trigger applied.
2. Clean edge: BOUNCE_COUNT=0, SETTLE_CYCLES=4; pulse trigger at T → o_bouncy=1 at T+1; o_done and o_clean=1 at T+5; o_busy high T+1..T+4.
3. Burst shape: BOUNCE_COUNT=3, GAP_WIDTH=4, default seed; trigger → exactly 7 edges on o_bouncy, each gap in 1..16 cycles and equal to the reference-model LFSR values; final level 1; o_clean=1 only at o_done. A second trigger → 7 edges, final level 0.
4. Busy rejection: pulse i_trigger 5 more times during BOUNCE and SETTLE → edge count and timing identical to the single-trigger run; exactly one o_done.
5. Reset mid-operation: assert reset after edge 4 of 7 → o_bouncy=0, o_clean=0, o_done never pulses; a fresh trigger restarts from edge 1 with the seed sequence.
6. Loopback: drive debounce_filter (DEBOUNCE_LIMIT=300) from o_bouncy with GAP_WIDTH=8 and SETTLE_CYCLES=1000; 10 triggers → debounced output changes exactly 10 times and matches o_clean after each o_done.
